// File: rtl/bus_fabric.sv
// Single-master address-decode fabric: posted writes, one tracked read with registered response.
// Optional read timeout built only when BUS_FABRIC_TIMEOUT_EN is defined.
module bus_fabric #(
    parameter int              W        = 32,
    parameter int              AW       = 16,
    parameter int              N        = 4,
    parameter logic [N*AW-1:0] SLV_BASE = '0,
    parameter logic [N*AW-1:0] SLV_MASK = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [AW-1:0]     i_m_addr,
    input  logic              i_m_ren,
    input  logic              i_m_wen,
    input  logic [W-1:0]      i_m_wdata,
    input  logic [W/8-1:0]    i_m_wr_mask,
    output logic [W-1:0]      o_m_rdata,
    output logic              o_m_rd_valid,
    output logic              o_m_err,
    output logic              o_m_busy,
    output logic [N-1:0]      o_s_ren,
    output logic [N-1:0]      o_s_wen,
    output logic [AW-1:0]     o_s_addr,
    output logic [W-1:0]      o_s_wdata,
    output logic [W/8-1:0]    o_s_wr_mask,
    input  logic [N*W-1:0]    i_s_rdata,
    input  logic [N-1:0]      i_s_rd_valid
);
    // state   | meaning
    // IDLE    | no read outstanding, requests accepted
    // WAIT    | read issued to slave r_idx, waiting for its rd_valid
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic [W-1:0]   r_rdata, w_rdata_nxt;
    logic           r_rd_valid, w_rd_valid_nxt;
    logic           r_err, w_err_nxt;

    logic [N-1:0]   w_hit;
    logic [IW-1:0]  w_sel;
    logic           w_miss;
    logic [AW-1:0]  w_mask_sel;
    logic [N-1:0]   w_sel_onehot;
    logic           w_busy;
    logic           w_rd_acc;
    logic           w_wr_acc;
    logic           w_idx_valid;
    logic [W-1:0]   w_idx_rdata;
    logic           w_timeout;

    // Walk from the top down so the lowest-index hit wins on overlap.
    always_comb begin
        w_hit      = '0;
        w_sel      = '0;
        w_mask_sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_hit[k] = ((i_m_addr & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]);
            if (w_hit[k]) begin
                w_sel      = IW'(k);
                w_mask_sel = SLV_MASK[k*AW +: AW];
            end
        end
        w_miss = ~|w_hit;
    end

    always_comb begin
        w_sel_onehot        = '0;
        w_sel_onehot[w_sel] = 1'b1;
    end

    assign w_busy      = (r_state == ST_WAIT);
    assign w_rd_acc    = i_m_ren & ~w_busy & ~w_miss;
    assign w_wr_acc    = i_m_wen & ~i_m_ren & ~w_busy & ~w_miss;

    assign o_s_ren     = w_rd_acc ? w_sel_onehot : '0;
    assign o_s_wen     = w_wr_acc ? w_sel_onehot : '0;
    assign o_s_addr    = i_m_addr & ~w_mask_sel;
    assign o_s_wdata   = i_m_wdata;
    assign o_s_wr_mask = i_m_wr_mask;

    assign w_idx_valid = i_s_rd_valid[r_idx];
    assign w_idx_rdata = i_s_rdata[r_idx*W +: W];

`ifdef BUS_FABRIC_TIMEOUT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if (!w_idx_valid) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // r_cnt holds (cycles since issue - 1), so this fires in cycle TIMEOUT.
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_rdata_nxt    = r_rdata;
        w_rd_valid_nxt = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_m_ren) begin
                    if (w_miss) begin
                        w_rd_valid_nxt = 1'b1;
                        w_err_nxt      = 1'b1;
                        w_rdata_nxt    = '0;
                    end else begin
                        w_idx_nxt   = w_sel;
                        w_state_nxt = ST_WAIT;
                    end
                end else if (i_m_wen && w_miss) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_idx_valid) begin
                    w_rd_valid_nxt = 1'b1;
                    w_rdata_nxt    = w_idx_rdata;
                    w_state_nxt    = ST_IDLE;
                end else if (w_timeout) begin
                    w_rd_valid_nxt = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_rdata_nxt    = '0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign o_m_rdata    = r_rdata;
    assign o_m_rd_valid = r_rd_valid;
    assign o_m_err      = r_err;
    assign o_m_busy     = w_busy;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed self-checking bench for bus_fabric using a 4-slave map.
// Timeout scenarios follow BUS_FABRIC_TIMEOUT_EN when defined.
module tb_bus_fabric;
    localparam int W  = 32;
    localparam int AW = 16;
    localparam int N  = 4;
    localparam logic [N*AW-1:0] BASE = {16'h5000, 16'h4000, 16'h8000, 16'h0000};
    localparam logic [N*AW-1:0] MASK = {16'hF000, 16'hF000, 16'h8000, 16'hC000};
    localparam int TO = 15;
`ifdef BUS_FABRIC_TIMEOUT_EN
    localparam int RESP_CYC = TO;
`else
    localparam int RESP_CYC = 30;
`endif

    logic           clk;
    logic           rst_n;
    logic [AW-1:0]  m_addr;
    logic           m_ren, m_wen;
    logic [W-1:0]   m_wdata;
    logic [W/8-1:0] m_wr_mask;
    logic [W-1:0]   m_rdata;
    logic           m_rd_valid, m_err, m_busy;
    logic [N-1:0]   s_ren, s_wen;
    logic [AW-1:0]  s_addr;
    logic [W-1:0]   s_wdata;
    logic [W/8-1:0] s_wr_mask;
    logic [N*W-1:0] s_rdata;
    logic [N-1:0]   s_rd_valid;

    int n_checks = 0;
    int n_errs   = 0;

    bus_fabric #(.W(W), .AW(AW), .N(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_addr(m_addr), .i_m_ren(m_ren), .i_m_wen(m_wen),
        .i_m_wdata(m_wdata), .i_m_wr_mask(m_wr_mask),
        .o_m_rdata(m_rdata), .o_m_rd_valid(m_rd_valid), .o_m_err(m_err), .o_m_busy(m_busy),
        .o_s_ren(s_ren), .o_s_wen(s_wen), .o_s_addr(s_addr),
        .o_s_wdata(s_wdata), .o_s_wr_mask(s_wr_mask),
        .i_s_rdata(s_rdata), .i_s_rd_valid(s_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        m_ren      = 1'b0;
        m_wen      = 1'b0;
        s_rd_valid = '0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        m_addr     = '0;
        m_ren      = 1'b0;
        m_wen      = 1'b0;
        m_wdata    = '0;
        m_wr_mask  = '0;
        s_rdata    = '0;
        s_rd_valid = '0;

        // Reset state
        sample();
        check("rst_rdata", m_rdata, 0);
        check("rst_rd_valid", m_rd_valid, 0);
        check("rst_err", m_err, 0);
        check("rst_busy", m_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        next_cyc();

        // Mapped read, 1-cycle slave 0
        m_addr = 16'h0010; m_ren = 1'b1;
        sample();
        check("rd0_s_ren", s_ren, 4'b0001);
        check("rd0_s_addr", s_addr, 16'h0010);
        check("rd0_busy_c0", m_busy, 0);
        next_cyc();
        s_rdata[0*W +: W] = 32'h12345678; s_rd_valid = 4'b0001;
        sample();
        check("rd0_busy_c1", m_busy, 1);
        check("rd0_valid_c1", m_rd_valid, 0);
        next_cyc();
        sample();
        check("rd0_valid_c2", m_rd_valid, 1);
        check("rd0_rdata", m_rdata, 32'h12345678);
        check("rd0_err", m_err, 0);
        check("rd0_busy_c2", m_busy, 0);
        next_cyc();
        sample();
        check("rd0_valid_pulse", m_rd_valid, 0);
        check("rd0_rdata_hold", m_rdata, 32'h12345678);
        next_cyc();

`ifdef BUS_FABRIC_TIMEOUT_EN
        // Silent slave 3 times out; late answer ignored
        m_addr = 16'h5004; m_ren = 1'b1;
        sample();
        check("to_s_ren", s_ren, 4'b1000);
        check("to_s_addr", s_addr, 16'h0004);
        next_cyc();
        for (int c = 1; c <= TO; c++) begin
            sample();
            check("to_busy", m_busy, 1);
            check("to_no_valid", m_rd_valid, 0);
            next_cyc();
        end
        sample();
        check("to_valid", m_rd_valid, 1);
        check("to_err", m_err, 1);
        check("to_rdata", m_rdata, 0);
        check("to_idle", m_busy, 0);
        next_cyc();
        for (int c = TO + 2; c <= 22; c++) begin
            if (c == 20) s_rd_valid = 4'b1000;
            sample();
            check("to_late_valid", m_rd_valid, 0);
            check("to_late_err", m_err, 0);
            next_cyc();
        end
`endif

        // Slave 3 answers at RESP_CYC: the last normal cycle with timeout, long wait without
        m_addr = 16'h5008; m_ren = 1'b1;
        sample();
        check("lat_s_ren", s_ren, 4'b1000);
        next_cyc();
        for (int c = 1; c <= RESP_CYC; c++) begin
            if (c == RESP_CYC) begin
                s_rdata[3*W +: W] = 32'h33334444; s_rd_valid = 4'b1000;
            end
            sample();
            check("lat_busy", m_busy, 1);
            next_cyc();
        end
        sample();
        check("lat_valid", m_rd_valid, 1);
        check("lat_err", m_err, 0);
        check("lat_rdata", m_rdata, 32'h33334444);
        next_cyc();

        // Unmapped read
        m_addr = 16'h6000; m_ren = 1'b1;
        sample();
        check("ur_s_ren", s_ren, 0);
        next_cyc();
        sample();
        check("ur_valid", m_rd_valid, 1);
        check("ur_err", m_err, 1);
        check("ur_rdata", m_rdata, 0);
        check("ur_busy", m_busy, 0);
        next_cyc();

        // Unmapped write
        m_addr = 16'h6000; m_wen = 1'b1; m_wdata = 32'h0BADF00D; m_wr_mask = 4'hF;
        sample();
        check("uw_s_wen", s_wen, 0);
        next_cyc();
        sample();
        check("uw_err", m_err, 1);
        check("uw_valid", m_rd_valid, 0);
        next_cyc();
        sample();
        check("uw_err_pulse", m_err, 0);
        next_cyc();

        // Mapped write to slave 2
        m_addr = 16'h4004; m_wen = 1'b1; m_wdata = 32'hAABBCCDD; m_wr_mask = 4'b0101;
        sample();
        check("mw_s_wen", s_wen, 4'b0100);
        check("mw_s_addr", s_addr, 16'h0004);
        check("mw_s_wdata", s_wdata, 32'hAABBCCDD);
        check("mw_s_mask", s_wr_mask, 4'b0101);
        next_cyc();
        sample();
        check("mw_no_err", m_err, 0);
        next_cyc();

        // Busy drop and stray response
        m_addr = 16'h8000; m_ren = 1'b1;
        sample();
        check("bz_s_ren", s_ren, 4'b0010);
        check("bz_s_addr", s_addr, 16'h0000);
        next_cyc();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                s_rdata[0*W +: W] = 32'hDEADBEEF; s_rd_valid = 4'b0001;
            end
            if (c == 3) begin
                m_addr = 16'h0004; m_wen = 1'b1;
            end
            if (c == 4) begin
                m_addr = 16'h0010; m_ren = 1'b1;
            end
            if (c == 5) begin
                s_rdata[1*W +: W] = 32'h11112222; s_rd_valid = 4'b0010;
            end
            sample();
            check("bz_busy", m_busy, 1);
            check("bz_no_valid", m_rd_valid, 0);
            if (c == 3) check("bz_wen_drop", s_wen, 0);
            if (c == 4) check("bz_ren_drop", s_ren, 0);
            next_cyc();
        end
        sample();
        check("bz_valid", m_rd_valid, 1);
        check("bz_rdata", m_rdata, 32'h11112222);
        check("bz_err", m_err, 0);
        check("bz_idle", m_busy, 0);
        next_cyc();

        // Read beats simultaneous write; back-to-back read; reset mid-WAIT
        m_addr = 16'h4000; m_ren = 1'b1; m_wen = 1'b1;
        sample();
        check("rw_s_ren", s_ren, 4'b0100);
        check("rw_s_wen", s_wen, 0);
        next_cyc();
        s_rdata[2*W +: W] = 32'h22223333; s_rd_valid = 4'b0100;
        sample();
        next_cyc();
        m_addr = 16'h0020; m_ren = 1'b1;
        sample();
        check("bb_valid", m_rd_valid, 1);
        check("bb_rdata", m_rdata, 32'h22223333);
        check("bb_s_ren", s_ren, 4'b0001);
        next_cyc();
        s_rd_valid = 4'b0001;
        #2 rst_n = 1'b0;
        #1;
        check("mr_busy", m_busy, 0);
        check("mr_valid", m_rd_valid, 0);
        check("mr_err", m_err, 0);
        check("mr_rdata", m_rdata, 0);
        m_addr = 16'h0010; m_ren = 1'b1;
        #1;
        check("mr_s_ren", s_ren, 4'b0001);
        next_cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) s_rd_valid = 4'b0001;
            sample();
            check("mr_no_resp", m_rd_valid, 0);
            check("mr_no_busy", m_busy, 0);
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised single-master memory-mapped interconnect that replaces the hard-wired address decode in the SoC top level. It decodes CPU `ren`/`wen` requests onto N slave ports using per-slave base/mask parameters and tracks each read until the selected slave answers. It returns the registered read data, or an error response for unmapped addresses and for slaves that never answer. It sits between `cpu` and the memory/peripheral blocks (`bram`, `spram`, `led`, `uart`, future slaves).

## Interface
- `W`, 32, data width; a multiple of 8.
- `AW`, 16, address width.
- `N`, 4, number of slave ports (1..8).
- `SLV_BASE`, 0, N×AW packed slave base addresses; slave k occupies bits [k*AW +: AW].
- `SLV_MASK`, 0, N×AW packed decode masks; slave k matches when `(m_addr & mask_k) == base_k`.
- `TIMEOUT`, 15, maximum number of cycles to wait for a slave's `rd_valid` (1..255).

Ports (name, direction, width, meaning):
- `clk` in 1: clock. One clock domain; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m_addr` in AW: CPU address.
- `m_ren` in 1: CPU read request, one-cycle pulse.
- `m_wen` in 1: CPU write request, one-cycle pulse.
- `m_wdata` in W: CPU write data.
- `m_wr_mask` in W/8: CPU byte enables.
- `m_rdata` out W: read data returned to the CPU.
- `m_rd_valid` out 1: read response strobe.
- `m_err` out 1: error strobe.
- `m_busy` out 1: a read is outstanding.
- `s_ren` out N: per-slave read request.
- `s_wen` out N: per-slave write request.
- `s_addr` out AW: `m_addr & ~mask_sel`, the slave-local offset.
- `s_wdata` out W, `s_wr_mask` out W/8: broadcast copies of the CPU write data and byte enables.
- `s_rdata` in N×W: slave k read data at [k*W +: W].
- `s_rd_valid` in N: per-slave read response.

## Operation
- **Decode.** `hit[k]` is the match test for slave k. `sel` is the lowest-index k with a hit; overlapping windows resolve by lowest index. `miss` = no hit.
- **Write path.** Writes are combinational and posted.
  - `s_wen[sel] = m_wen & ~miss & ~m_busy`.
  - A write to an unmapped address sets `m_err` for one cycle, one cycle later, with `m_rd_valid` low.
- **Read path.** A two-state FSM, IDLE and WAIT.
  - IDLE, `m_ren`, hit: `s_ren[sel]` = 1 in the same cycle. Capture `sel` into `idx` and clear the timeout counter. Go to WAIT.
  - IDLE, `m_ren`, miss: stay in IDLE. Next cycle, `m_rd_valid` = 1, `m_err` = 1, `m_rdata` = 0.
  - WAIT, `s_rd_valid[idx]`: register `s_rdata[idx]` into `m_rdata`. Next cycle, `m_rd_valid` = 1, `m_err` = 0. Go to IDLE.
  - WAIT, no valid: the counter increments. When the counter reaches TIMEOUT, respond next cycle with `m_rd_valid` = 1, `m_err` = 1, `m_rdata` = 0, and go to IDLE.
- **Busy.** `m_busy` = (state == WAIT).
  - `m_ren`/`m_wen` asserted while busy are dropped: no slave strobe, no response.
- **Stray responses.** `s_rd_valid` from any slave other than `idx`, or any `s_rd_valid` seen in IDLE, is ignored. This includes a late response after a timeout.
- **Simultaneous events.** `m_ren` and `m_wen` in the same cycle: the read takes priority and the write is dropped.

## Timing
- **Reset.** On `rst_n` low, asynchronously:
  - outputs `m_rdata`, `m_rd_valid`, `m_err` and `m_busy` = 0;
  - internal state = IDLE, counter = 0, `idx` = 0.
  - Combinational outputs follow their inputs, gated by `m_busy` = 0.
- **Reset mid-WAIT.** The outstanding read is abandoned and no response is produced.
- **Read latency.** From the `m_ren` cycle (cycle 0) to `m_rd_valid` = slave latency + 1.
  - A 1-cycle slave gives `m_rd_valid` at cycle 2.
  - An unmapped read gives `m_rd_valid` at cycle 1.
- **Timeout.** Valid at cycle TIMEOUT or earlier is a normal response. No valid by cycle TIMEOUT gives an error response at cycle TIMEOUT+1.
- **Back-to-back.** A new `m_ren` is accepted in the same cycle that `m_rd_valid` is high, because the state is already IDLE.
- **Strobes.** `m_rd_valid` and `m_err` are single-cycle pulses. `m_rdata` holds its value until the next response.

## Configuration
- **`BUS_FABRIC_TIMEOUT_EN` defined:** the timeout counter is built, and timed-out reads return an error as described above.
- **Not defined:**
  - the counter is removed and WAIT lasts until `s_rd_valid[idx]`, indefinitely;
  - `m_err` only ever signals unmapped accesses;
  - the `TIMEOUT` parameter is ignored.

## Test plan
All scenarios use N=4 with this map: slave 0 base 0x0000 mask 0xC000; slave 1 base 0x8000 mask 0x8000; slave 2 base 0x4000 mask 0xF000; slave 3 base 0x5000 mask 0xF000.
- **Mapped read:** read 0x0010, slave 0 responds 0x12345678 one cycle later → `s_ren` = 4'b0001, `s_addr` = 0x0010, `m_rd_valid` at cycle 2, `m_rdata` = 0x12345678, `m_err` = 0.
- **Unmapped read and write:** read 0x6000 → `m_rd_valid` = 1, `m_err` = 1, `m_rdata` = 0 at cycle 1, no `s_ren`. Write 0x6000 → `m_err` pulse alone at cycle 1.
- **Timeout:** with `BUS_FABRIC_TIMEOUT_EN` and TIMEOUT=15, read 0x5004 and slave 3 stays silent → error response at cycle 16. A late `s_rd_valid[3]` at cycle 20 → no response.
- **Busy drop and stray response:** read 0x8000 with slave 1 answering at cycle 5 and a stray `s_rd_valid[0]` at cycle 2; write 0x0004 at cycle 3 → write dropped (`s_wen` = 0), stray ignored, `m_rd_valid` at cycle 6 carrying slave 1 data, `m_busy` high during cycles 1–5.
- **Back-to-back and reset:** a second read issued in the response cycle → `s_ren` in that cycle. Drive `rst_n` low mid-WAIT → all outputs 0 immediately and no response afterwards.
